mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the 16-bit CPU, between the EX/MEM register and the `mem_wb` register. For loads and stores it runs a request/acknowledge transaction with the external memory controller. While the transaction is in flight it holds the pipeline with a stall request. It then presents the final write-back triple (data, enable, register address) to `mem_wb`. Non-memory instructions pass through combinationally with zero added latency. A timeout counter aborts hung accesses and suppresses write-back.

## Interface
- `TIMEOUT`, 255: maximum BUSY cycles without `memAck_i` before abort; 1..255.
- `clk`  in  1  pipeline clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `memRead_i`  in  1  load request from EX/MEM.
- `memWrite_i`  in  1  store request from EX/MEM.
- `memAddr_i`  in  16  word address.
- `memWData_i`  in  16  store data.
- `wData_i`  in  16  ALU result or write-back data from EX/MEM.
- `wReg_i`  in  1  register write enable from EX/MEM.
- `wRegAddr_i`  in  4  destination register.
- `memRData_i`  in  16  read data from the memory controller; valid only when `memAck_i` is high.
- `memAck_i`  in  1  single-cycle completion strobe from the memory controller.
- `memReq_o`  out  1  transaction request; held high until acknowledged.
- `memWe_o`  out  1  1 = write, 0 = read; valid while `memReq_o` is high.
- `memAddr_o`  out  16  access address.
- `memWData_o`  out  16  store data.
- `stallReq_o`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; inserts a bubble into `mem_wb`.
- `fault_o`  out  1  one-cycle pulse on timeout abort.
- `wData_o`  out  16  write-back data to `mem_wb`.
- `wReg_o`  out  1  write-back enable to `mem_wb`.
- `wRegAddr_o`  out  4  write-back register to `mem_wb`.

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: `state`, `loadData`[15:0], `timer`[7:0], `faultFlag`.
- `memOp = memRead_i | memWrite_i`. If both are high, the access is a read and the write is ignored.
- IDLE, `memOp`=0:
  - `wData_o`/`wReg_o`/`wRegAddr_o` equal the inputs combinationally.
  - `stallReq_o`=0; stay IDLE.
- IDLE, `memOp`=1:
  - `stallReq_o`=1 combinationally.
  - `wReg_o`=0 (bubble into `mem_wb`).
  - Next state BUSY; `timer` set to 0.
- BUSY:
  - `memReq_o`=1; `memWe_o` = `memWrite_i & ~memRead_i`.
  - `memAddr_o` = `memAddr_i`; `memWData_o` = `memWData_i`. EX/MEM holds these stable because of the stall.
  - `stallReq_o`=1; `wReg_o`=0.
  - `timer` increments each cycle.
  - On `memAck_i`: latch `memRData_i` into `loadData`; next state DONE with `faultFlag`=0.
  - Else if `timer` == `TIMEOUT`-1: next state DONE with `faultFlag`=1.
- DONE:
  - `stallReq_o`=0; `memReq_o`=0.
  - `wData_o` = `loadData` for reads, `wData_i` for writes; `wRegAddr_o` = `wRegAddr_i`.
  - `wReg_o` = `wReg_i & ~faultFlag`; `fault_o` = `faultFlag`.
  - Next state IDLE unconditionally. EX/MEM advances at the end of this cycle, so the same op is never re-issued.
- `memAck_i` outside BUSY is ignored.
- Memory outputs outside BUSY: `memReq_o`=0, `memWe_o`=0, `memAddr_o`=0, `memWData_o`=0.

## Timing
- Reset (`rst` low, asynchronous): `state`=IDLE, `loadData`=0, `timer`=0, `faultFlag`=0.
- Output values while `rst` is low: all outputs are 0, including the pass-through outputs.
- Reset released mid-transaction: the transaction is dropped, nothing is written back, and the FSM starts in IDLE.
- Pass-through latency: 0 cycles, combinational.
- Memory op accepted in IDLE at cycle 0:
  - BUSY from cycle 1.
  - Ack at BUSY cycle k (k ≥ 1) puts DONE at cycle k+1.
  - Stall cycles: k+1. Minimum 2 (ack in the first BUSY cycle).
- Timeout: `TIMEOUT` BUSY cycles, then DONE. Stall length is `TIMEOUT`+1 cycles.
- Back-to-back memory ops: DONE → IDLE, and the next op is seen in IDLE. This gives one non-stalled cycle between transactions.
- `memReq_o` is a pure function of state, so it is glitch-free relative to `clk`.

## Test plan
- Reset: `rst`=0 with `memRead_i`=1 → all outputs 0. Release `rst` → state IDLE, `memReq_o`=0.
- ALU pass-through: `wData_i`=0x1234, `wReg_i`=1, `wRegAddr_i`=5, no mem op → same cycle `wData_o`=0x1234, `wReg_o`=1, `wRegAddr_o`=5, `stallReq_o`=0.
- Load, ack after 3 BUSY cycles with `memRData_i`=0xBEEF at `memAddr_i`=0x8000:
  - `stallReq_o` high for 4 cycles.
  - `memReq_o` high for 3 cycles with `memWe_o`=0 and `memAddr_o`=0x8000.
  - DONE: `wData_o`=0xBEEF, `wReg_o`=1.
- Store 0x00FF to 0x9000, ack in the first BUSY cycle:
  - `memWe_o`=1, `memWData_o`=0x00FF.
  - Stall lasts 2 cycles.
  - DONE passes through `wReg_i`=0.
- Timeout with `TIMEOUT`=4, no ack:
  - `memReq_o` high for 4 cycles, then `fault_o`=1 for one cycle.
  - `wReg_o`=0 despite `wReg_i`=1.
  - A late `memAck_i` in IDLE is ignored.
- Async reset asserted in the middle of BUSY:
  - `memReq_o` and `stallReq_o` drop immediately.
  - After release, a new load completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs req/ack transactions for loads and stores,
// stalls the pipeline while in flight, and drives the write-back triple to mem_wb.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic [15:0] memAddr_i,
  input  logic [15:0] memWData_i,
  input  logic [15:0] wData_i,
  input  logic        wReg_i,
  input  logic [3:0]  wRegAddr_i,
  input  logic [15:0] memRData_i,
  input  logic        memAck_i,
  output logic        memReq_o,
  output logic        memWe_o,
  output logic [15:0] memAddr_o,
  output logic [15:0] memWData_o,
  output logic        stallReq_o,
  output logic        fault_o,
  output logic [15:0] wData_o,
  output logic        wReg_o,
  output logic [3:0]  wRegAddr_o
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_load_data;
  logic [DATA_W-1:0]   w_load_data;
  logic [TIMER_W-1:0]  r_timer;
  logic [TIMER_W-1:0]  w_timer;
  logic                r_fault_flag;
  logic                w_fault_flag;
  logic                w_mem_op;

  assign w_mem_op = memRead_i | memWrite_i;

  // State and transaction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_load_data  <= '0;
      r_timer      <= '0;
      r_fault_flag <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_load_data  <= w_load_data;
      r_timer      <= w_timer;
      r_fault_flag <= w_fault_flag;
    end
  end

  // Next-state and output decode; outputs are forced low while reset is held
  always_comb begin
    w_next_state = r_state;
    w_load_data  = r_load_data;
    w_timer      = r_timer;
    w_fault_flag = r_fault_flag;
    memReq_o     = 1'b0;
    memWe_o      = 1'b0;
    memAddr_o    = '0;
    memWData_o   = '0;
    stallReq_o   = 1'b0;
    fault_o      = 1'b0;
    wData_o      = wData_i;
    wReg_o       = wReg_i;
    wRegAddr_o   = wRegAddr_i;

    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          stallReq_o   = 1'b1;
          wReg_o       = 1'b0;
          w_timer      = '0;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        memReq_o   = 1'b1;
        memWe_o    = memWrite_i & ~memRead_i;
        memAddr_o  = memAddr_i;
        memWData_o = memWData_i;
        stallReq_o = 1'b1;
        wReg_o     = 1'b0;
        w_timer    = r_timer + TIMER_W'(1);
        if (memAck_i) begin
          w_load_data  = memRData_i;
          w_fault_flag = 1'b0;
          w_next_state = DONE;
        end else if (r_timer == TIMER_LAST) begin
          w_fault_flag = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        wData_o      = memRead_i ? r_load_data : wData_i;
        wReg_o       = wReg_i & ~r_fault_flag;
        fault_o      = r_fault_flag;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    if (!rst) begin
      memReq_o   = 1'b0;
      memWe_o    = 1'b0;
      memAddr_o  = '0;
      memWData_o = '0;
      stallReq_o = 1'b0;
      fault_o    = 1'b0;
      wData_o    = '0;
      wReg_o     = 1'b0;
      wRegAddr_o = '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT=4).
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        memRead_i;
  logic        memWrite_i;
  logic [15:0] memAddr_i;
  logic [15:0] memWData_i;
  logic [15:0] wData_i;
  logic        wReg_i;
  logic [3:0]  wRegAddr_i;
  logic [15:0] memRData_i;
  logic        memAck_i;
  logic        memReq_o;
  logic        memWe_o;
  logic [15:0] memAddr_o;
  logic [15:0] memWData_o;
  logic        stallReq_o;
  logic        fault_o;
  logic [15:0] wData_o;
  logic        wReg_o;
  logic [3:0]  wRegAddr_o;

  int total = 0;
  int bad   = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .memRead_i  (memRead_i),
    .memWrite_i (memWrite_i),
    .memAddr_i  (memAddr_i),
    .memWData_i (memWData_i),
    .wData_i    (wData_i),
    .wReg_i     (wReg_i),
    .wRegAddr_i (wRegAddr_i),
    .memRData_i (memRData_i),
    .memAck_i   (memAck_i),
    .memReq_o   (memReq_o),
    .memWe_o    (memWe_o),
    .memAddr_o  (memAddr_o),
    .memWData_o (memWData_o),
    .stallReq_o (stallReq_o),
    .fault_o    (fault_o),
    .wData_o    (wData_o),
    .wReg_o     (wReg_o),
    .wRegAddr_o (wRegAddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation record of one memory transaction
  typedef struct {
    int          stalls;
    int          reqs;
    int          faults;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [15:0] done_wdata;
    logic        done_wreg;
    logic [3:0]  done_ra;
    logic        done_fault;
    logic        finished;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op from IDLE (called at posedge+1), acks at BUSY cycle ack_at (0 = never)
  task automatic drive_op(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] alu, input logic wreg,
                          input logic [3:0] ra, input int ack_at, input logic [15:0] rdata,
                          output obs_t o);
    o = '{default: '0};
    memRead_i  = rd;
    memWrite_i = wr;
    memAddr_i  = addr;
    memWData_i = wd;
    wData_i    = alu;
    wReg_i     = wreg;
    wRegAddr_i = ra;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #2;
      if (stallReq_o) o.stalls++;
      if (fault_o) o.faults++;
      if (memReq_o) begin
        o.reqs++;
        o.req_we    = memWe_o;
        o.req_addr  = memAddr_o;
        o.req_wdata = memWData_o;
        if (o.reqs == ack_at) begin
          memAck_i   = 1'b1;
          memRData_i = rdata;
        end
      end
      if (cyc > 0 && !stallReq_o) begin
        o.done_wdata = wData_o;
        o.done_wreg  = wReg_o;
        o.done_ra    = wRegAddr_o;
        o.done_fault = fault_o;
        o.finished   = 1'b1;
      end
      tick();
      memAck_i   = 1'b0;
      memRData_i = 16'h0000;
      if (o.finished) break;
    end
    memRead_i  = 1'b0;
    memWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    memRead_i  = 1'b1;
    memWrite_i = 1'b0;
    memAddr_i  = 16'h1111;
    memWData_i = 16'h2222;
    wData_i    = 16'h3333;
    wReg_i     = 1'b1;
    wRegAddr_i = 4'h7;
    memRData_i = 16'h0;
    memAck_i   = 1'b0;
    tick();
    tick();
    total++;
    if ({memReq_o, memWe_o, memAddr_o, memWData_o, stallReq_o, fault_o, wData_o, wReg_o, wRegAddr_o} !== 57'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {memReq_o, memWe_o, memAddr_o, memWData_o,
               stallReq_o, fault_o, wData_o, wReg_o, wRegAddr_o});
    end
    memRead_i = 1'b0;
    rst = 1'b1;
    tick();
    total++;
    if (memReq_o !== 1'b0) begin bad++; $display("FAIL reset_release_req: got %b want 0", memReq_o); end
    total++;
    if (stallReq_o !== 1'b0) begin bad++; $display("FAIL reset_release_stall: got %b want 0", stallReq_o); end
  endtask

  task automatic test_passthrough();
    logic [15:0] d_vec [2];
    logic        w_vec [2];
    logic [3:0]  a_vec [2];
    d_vec[0] = 16'h1234; w_vec[0] = 1'b1; a_vec[0] = 4'd5;
    d_vec[1] = 16'hA5A5; w_vec[1] = 1'b0; a_vec[1] = 4'hF;
    for (int i = 0; i < 2; i++) begin
      wData_i = d_vec[i]; wReg_i = w_vec[i]; wRegAddr_i = a_vec[i];
      #1;
      total++;
      if ({wData_o, wReg_o, wRegAddr_o} !== {d_vec[i], w_vec[i], a_vec[i]}) begin
        bad++;
        $display("FAIL passthru_%0d: got %h/%b/%h want %h/%b/%h", i, wData_o, wReg_o, wRegAddr_o,
                 d_vec[i], w_vec[i], a_vec[i]);
      end
      total++;
      if ({stallReq_o, memReq_o} !== 2'b00) begin
        bad++; $display("FAIL passthru_stall_%0d: got %b%b want 00", i, stallReq_o, memReq_o);
      end
      tick();
    end
  endtask

  task automatic test_load();
    obs_t o;
    drive_op(1'b1, 1'b0, 16'h8000, 16'h0, 16'h1111, 1'b1, 4'd3, 3, 16'hBEEF, o);
    total++; if (!o.finished) begin bad++; $display("FAIL load_finish: got 0 want 1"); end
    total++; if (o.stalls != 4) begin bad++; $display("FAIL load_stalls: got %0d want 4", o.stalls); end
    total++; if (o.reqs != 3) begin bad++; $display("FAIL load_reqs: got %0d want 3", o.reqs); end
    total++; if ({o.req_we, o.req_addr} !== {1'b0, 16'h8000}) begin
      bad++; $display("FAIL load_req: got we=%b addr=%h want we=0 addr=8000", o.req_we, o.req_addr);
    end
    total++; if ({o.done_wdata, o.done_wreg, o.done_ra, o.done_fault} !== {16'hBEEF, 1'b1, 4'd3, 1'b0}) begin
      bad++; $display("FAIL load_done: got %h/%b/%h/%b want beef/1/3/0", o.done_wdata, o.done_wreg,
                      o.done_ra, o.done_fault);
    end
  endtask

  task automatic test_store();
    obs_t o;
    drive_op(1'b0, 1'b1, 16'h9000, 16'h00FF, 16'h0042, 1'b0, 4'd9, 1, 16'hDEAD, o);
    total++; if (o.stalls != 2) begin bad++; $display("FAIL store_stalls: got %0d want 2", o.stalls); end
    total++; if ({o.req_we, o.req_addr, o.req_wdata} !== {1'b1, 16'h9000, 16'h00FF}) begin
      bad++; $display("FAIL store_req: got %b/%h/%h want 1/9000/00ff", o.req_we, o.req_addr, o.req_wdata);
    end
    total++; if ({o.done_wdata, o.done_wreg, o.done_ra} !== {16'h0042, 1'b0, 4'd9}) begin
      bad++; $display("FAIL store_done: got %h/%b/%h want 0042/0/9", o.done_wdata, o.done_wreg, o.done_ra);
    end
  endtask

  task automatic test_read_wins();
    obs_t o;
    drive_op(1'b1, 1'b1, 16'h0010, 16'h5555, 16'h0, 1'b1, 4'd1, 2, 16'h7777, o);
    total++; if (o.req_we !== 1'b0) begin bad++; $display("FAIL rdwr_we: got %b want 0", o.req_we); end
    total++; if (o.done_wdata !== 16'h7777) begin
      bad++; $display("FAIL rdwr_data: got %h want 7777", o.done_wdata);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_op(1'b1, 1'b0, 16'h4000, 16'h0, 16'h0, 1'b1, 4'd2, 0, 16'h0, o);
    total++; if (o.reqs != 4) begin bad++; $display("FAIL tmo_reqs: got %0d want 4", o.reqs); end
    total++; if (o.stalls != 5) begin bad++; $display("FAIL tmo_stalls: got %0d want 5", o.stalls); end
    total++; if ({o.done_fault, o.faults} != {1'b1, 32'd1}) begin
      bad++; $display("FAIL tmo_fault: got %b/%0d want 1/1", o.done_fault, o.faults);
    end
    total++; if (o.done_wreg !== 1'b0) begin bad++; $display("FAIL tmo_wreg: got %b want 0", o.done_wreg); end
    memAck_i = 1'b1; memRData_i = 16'hFFFF; wReg_i = 1'b1;
    #1;
    total++; if ({memReq_o, stallReq_o, fault_o, wReg_o} !== 4'b0001) begin
      bad++; $display("FAIL late_ack: got %b%b%b%b want 0001", memReq_o, stallReq_o, fault_o, wReg_o);
    end
    tick();
    memAck_i = 1'b0; memRData_i = 16'h0;
    #1;
    total++; if ({memReq_o, stallReq_o, fault_o} !== 3'b000) begin
      bad++; $display("FAIL late_ack_after: got %b%b%b want 000", memReq_o, stallReq_o, fault_o);
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    memRead_i = 1'b1; memAddr_i = 16'h6000; wReg_i = 1'b1; wRegAddr_i = 4'd4;
    tick();
    tick();
    #2;
    total++; if ({memReq_o, stallReq_o} !== 2'b11) begin
      bad++; $display("FAIL arst_busy: got %b%b want 11", memReq_o, stallReq_o);
    end
    rst = 1'b0;
    #1;
    total++; if ({memReq_o, stallReq_o, wReg_o} !== 3'b000) begin
      bad++; $display("FAIL arst_drop: got %b%b%b want 000", memReq_o, stallReq_o, wReg_o);
    end
    tick();
    memRead_i = 1'b0;
    rst = 1'b1;
    tick();
    drive_op(1'b1, 1'b0, 16'h6002, 16'h0, 16'h0, 1'b1, 4'd4, 2, 16'hCAFE, o);
    total++; if ({o.stalls, o.done_wdata, o.done_wreg} != {32'd3, 16'hCAFE, 1'b1}) begin
      bad++; $display("FAIL arst_reload: got %0d/%h/%b want 3/cafe/1", o.stalls, o.done_wdata, o.done_wreg);
    end
  endtask

  task automatic test_back_to_back();
    obs_t a;
    obs_t b;
    drive_op(1'b1, 1'b0, 16'h0100, 16'h0, 16'h0, 1'b1, 4'd6, 1, 16'h1357, a);
    drive_op(1'b0, 1'b1, 16'h0102, 16'h2468, 16'h0AAA, 1'b1, 4'd8, 1, 16'h0, b);
    total++; if ({a.stalls, a.done_wdata} != {32'd2, 16'h1357}) begin
      bad++; $display("FAIL b2b_first: got %0d/%h want 2/1357", a.stalls, a.done_wdata);
    end
    total++; if ({b.stalls, b.req_addr, b.req_wdata, b.done_wdata, b.done_wreg} !=
                 {32'd2, 16'h0102, 16'h2468, 16'h0AAA, 1'b1}) begin
      bad++; $display("FAIL b2b_second: got %0d/%h/%h/%h/%b want 2/0102/2468/0aaa/1", b.stalls,
                      b.req_addr, b.req_wdata, b.done_wdata, b.done_wreg);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_read_wins();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
